// File: rtl/audio_i2s_rx_cs5343.sv
// I2S receiver for a CS5343-style ADC: generates MCLK/SCLK/LRCK, deserialises
// 24-bit left/right samples and presents them through a valid/ready port.
`timescale 1ns/1ps
module audio_i2s_rx_cs5343 #(
  parameter int SCLK_HALF     = 16,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCK,
  input  logic        SDOUT,
  output logic [23:0] LeftData,
  output logic [23:0] RightData,
  output logic        SampleValid,
  input  logic        SampleReady,
  output logic        Overrun,
  input  logic        OverrunClr,
  output logic [1:0]  DbgState
);

  // Handshake: a pair transfers on any Clk edge with SampleValid=1 and
  // SampleReady=1; SampleValid and the data hold until then, except that a
  // newer pair may overwrite an unconsumed one (flagged by Overrun).

  typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, RUN = 2'd2} state_t;

  localparam logic [7:0] DIV_MAX   = 8'(SCLK_HALF - 1);
  localparam logic [3:0] WARM_LAST = 4'(WARMUP_FRAMES - 1);

  state_t      state_q, state_d;
  logic        mclk_div_q, mclk_div_d;
  logic        mclk_q, mclk_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  warm_q, warm_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] hold_q, hold_d;
  logic        post_q, post_d;
  logic [23:0] left_q, left_d;
  logic [23:0] right_q, right_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;

  logic        tick, rise, fall;
  logic [4:0]  slot;

  always_comb begin
    state_d    = state_q;
    mclk_div_d = ~mclk_div_q;
    mclk_d     = mclk_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    bitcnt_d   = bitcnt_q;
    warm_d     = warm_q;
    sync1_d    = SDOUT;
    sync2_d    = sync1_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    post_d     = 1'b0;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    tick       = (div_q == DIV_MAX);
    rise       = 1'b0;
    fall       = 1'b0;
    slot       = bitcnt_q[4:0];

    if (mclk_div_q) mclk_d = ~mclk_q;

    // The divider runs whenever the next state is not IDLE, so the first SCLK
    // rise lands exactly SCLK_HALF edges after Enable is seen.
    if (!Enable) begin
      state_d  = IDLE;
      div_d    = 8'd0;
      sclk_d   = 1'b0;
      bitcnt_d = 6'd0;
      warm_d   = 4'd0;
      shift_d  = 24'd0;
    end else begin
      if (state_q == IDLE) state_d = (WARMUP_FRAMES == 0) ? RUN : WARMUP;
      if (tick) begin
        div_d  = 8'd0;
        sclk_d = ~sclk_q;
        rise   = ~sclk_q;
        fall   = sclk_q;
      end else begin
        div_d = div_q + 8'd1;
      end
      if (fall) begin
        bitcnt_d = bitcnt_q + 6'd1;
        if (bitcnt_q == 6'd63 && state_q == WARMUP) begin
          warm_d = warm_q + 4'd1;
          if (warm_q == WARM_LAST) state_d = RUN;
        end
      end
      // Slot 0 is the I2S delay bit; slots 1..24 carry MSB-first data.
      if (rise && slot >= 5'd1 && slot <= 5'd24) begin
        shift_d = {shift_q[22:0], sync2_q};
        if (slot == 5'd24) begin
          if (!bitcnt_q[5]) hold_d = shift_d;
          else if (state_q == RUN) post_d = 1'b1;
        end
      end
    end

    if (post_q) begin
      left_d  = hold_q;
      right_d = shift_q;
      valid_d = 1'b1;
      if (valid_q && !SampleReady) ovr_d = 1'b1;
      else if (OverrunClr) ovr_d = 1'b0;
    end else begin
      if (valid_q && SampleReady) valid_d = 1'b0;
      if (OverrunClr) ovr_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      mclk_div_q <= 1'b0;
      mclk_q     <= 1'b0;
      div_q      <= 8'd0;
      sclk_q     <= 1'b0;
      bitcnt_q   <= 6'd0;
      warm_q     <= 4'd0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      shift_q    <= 24'd0;
      hold_q     <= 24'd0;
      post_q     <= 1'b0;
      left_q     <= 24'd0;
      right_q    <= 24'd0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mclk_div_q <= mclk_div_d;
      mclk_q     <= mclk_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      bitcnt_q   <= bitcnt_d;
      warm_q     <= warm_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      post_q     <= post_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign MCLK        = mclk_q;
  assign SCLK        = sclk_q;
  assign LRCK        = bitcnt_q[5];
  assign LeftData    = left_q;
  assign RightData   = right_q;
  assign SampleValid = valid_q;
  assign Overrun     = ovr_q;
  assign DbgState    = state_q;

endmodule

// File: tb/tb_audio_i2s_rx_cs5343.sv
// Bench for audio_i2s_rx_cs5343: default-parameter instance driven by directed
// frame vectors, plus a fast instance checked against a random sample stream.
`timescale 1ns/1ps
module tb_audio_i2s_rx_cs5343;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- instance A (defaults) ----------------
  logic rst_a = 1'b1, en_a = 1'b0, sd_a = 1'b0, rdy_a = 1'b0, clr_a = 1'b0;
  logic mclk_a, sclk_a, lrck_a, val_a, ovr_a;
  logic [23:0] l_a, r_a;
  logic [1:0] st_a;

  audio_i2s_rx_cs5343 dut_a (
    .Clk(clk), .Rst(rst_a), .Enable(en_a), .MCLK(mclk_a), .SCLK(sclk_a),
    .LRCK(lrck_a), .SDOUT(sd_a), .LeftData(l_a), .RightData(r_a),
    .SampleValid(val_a), .SampleReady(rdy_a), .Overrun(ovr_a),
    .OverrunClr(clr_a), .DbgState(st_a)
  );

  // ---------------- instance B (fast, no warmup) ----------------
  logic rst_b = 1'b1, en_b = 1'b0, sd_b = 1'b0, rdy_b = 1'b1, clr_b = 1'b0;
  logic mclk_b, sclk_b, lrck_b, val_b, ovr_b;
  logic [23:0] l_b, r_b;
  logic [1:0] st_b;

  audio_i2s_rx_cs5343 #(.SCLK_HALF(4), .WARMUP_FRAMES(0)) dut_b (
    .Clk(clk), .Rst(rst_b), .Enable(en_b), .MCLK(mclk_b), .SCLK(sclk_b),
    .LRCK(lrck_b), .SDOUT(sd_b), .LeftData(l_b), .RightData(r_b),
    .SampleValid(val_b), .SampleReady(rdy_b), .Overrun(ovr_b),
    .OverrunClr(clr_b), .DbgState(st_b)
  );

  // ---------------- ADC models (I2S, data changes on SCLK fall) ----------------
  function automatic logic adc_bit(input logic [23:0] w, input int i);
    return (i >= 1 && i <= 24) ? w[24-i] : 1'b0;
  endfunction

  logic [23:0] cur_l = 24'd0, cur_r = 24'd0;
  logic prev_a = 1'b0;
  int   idx_a  = 0;
  always @(negedge sclk_a or negedge en_a or posedge rst_a) begin
    if (rst_a || !en_a) begin
      prev_a = 1'b0; idx_a = 0; sd_a = 1'b0;
    end else begin
      if (lrck_a != prev_a) idx_a = 0; else idx_a++;
      prev_a = lrck_a;
      sd_a = adc_bit(lrck_a ? cur_r : cur_l, idx_a);
    end
  end

  logic [23:0] bl [0:127];
  logic [23:0] br [0:127];
  logic prev_b = 1'b0;
  int   idx_b  = 0;
  int   fb     = 0;
  always @(negedge sclk_b or negedge en_b or posedge rst_b) begin
    if (rst_b || !en_b) begin
      prev_b = 1'b0; idx_b = 0; sd_b = 1'b0;
    end else begin
      if (lrck_b != prev_b) begin
        idx_b = 0;
        if (!lrck_b) fb++;
      end else idx_b++;
      prev_b = lrck_b;
      sd_b = adc_bit(lrck_b ? br[fb] : bl[fb], idx_b);
    end
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_mclk"},  mclk_a, 0);
    chk({tag, "_sclk"},  sclk_a, 0);
    chk({tag, "_lrck"},  lrck_a, 0);
    chk({tag, "_valid"}, val_a,  0);
    chk({tag, "_ovr"},   ovr_a,  0);
    chk({tag, "_data"},  {l_a, r_a}, 0);
    chk({tag, "_state"}, st_a,   0);
  endtask

  task automatic wait_lvl_a(input logic lvl, input int budget);
    int c = 0;
    while (lrck_a !== lvl && c < budget) begin @(negedge clk); c++; end
    if (lrck_a !== lvl) tmo("lrck_wait");
  endtask

  task automatic edges_a(input int n, input logic lvl, input int budget);
    int   seen = 0;
    int   c    = 0;
    logic prev = sclk_a;
    while (seen < n && c < budget) begin
      @(negedge clk); c++;
      if (sclk_a === lvl && prev !== lvl) seen++;
      prev = sclk_a;
    end
    if (seen < n) tmo("sclk_edges");
  endtask

  // Waits for the next frame's right-slot-24 sample, optionally driving
  // SampleReady / OverrunClr on the cycle in which the pair posts.
  task automatic wait_post(input bit rdy_at, input bit clr_at);
    wait_lvl_a(1'b0, 4096);
    wait_lvl_a(1'b1, 4096);
    edges_a(25, 1'b1, 4096);
    rdy_a = rdy_at; clr_a = clr_at;
    @(negedge clk);
    rdy_a = 1'b0; clr_a = 1'b0;
  endtask

  // ---------------- directed frame vectors ----------------
  typedef struct {
    logic [23:0] l, r;
    bit rdy_pre, clr_pre, rdy_post, clr_post;
    logic exp_v, exp_o;
    logic [23:0] exp_l, exp_r;
  } vec_t;

  vec_t tbl [9];

  task automatic run_a();
    int c;
    tbl[0] = '{24'h123456, 24'h654321, 0, 0, 0, 0, 1, 0, 24'h123456, 24'h654321};
    tbl[1] = '{24'h0000AA, 24'hFFFF00, 0, 0, 0, 0, 1, 1, 24'h0000AA, 24'hFFFF00};
    tbl[2] = '{24'h000001, 24'hFFFFFF, 1, 1, 0, 0, 1, 0, 24'h000001, 24'hFFFFFF};
    tbl[3] = '{24'hABCDEF, 24'h012345, 0, 0, 1, 0, 1, 0, 24'hABCDEF, 24'h012345};
    tbl[4] = '{24'h800000, 24'h7FFFFF, 1, 0, 0, 0, 1, 0, 24'h800000, 24'h7FFFFF};
    tbl[5] = '{24'h555555, 24'hAAAAAA, 0, 0, 0, 0, 1, 1, 24'h555555, 24'hAAAAAA};
    tbl[6] = '{24'h000000, 24'h000000, 1, 0, 0, 0, 1, 1, 24'h000000, 24'h000000};
    tbl[7] = '{24'h13579B, 24'h2468AC, 0, 0, 0, 1, 1, 1, 24'h13579B, 24'h2468AC};
    tbl[8] = '{24'hFEDCBA, 24'hC0FFEE, 1, 1, 0, 0, 1, 0, 24'hFEDCBA, 24'hC0FFEE};

    repeat (3) @(negedge clk);
    chk_reset_a("a_reset");
    rst_a = 1'b0;
    cur_l = 24'h7FFFFF; cur_r = 24'h800001;
    @(negedge clk);
    en_a = 1'b1;

    // Warmup: two frames discarded, first post at right slot 24 of frame 2.
    c = 0;
    while (!val_a && c < 7000) begin @(negedge clk); c++; end
    if (!val_a) tmo("a_first_post");
    chk("a_first_post_cycle", c, 5905);
    chk("a_first_pair", {l_a, r_a}, {24'h7FFFFF, 24'h800001});
    chk("a_first_ovr", ovr_a, 0);
    rdy_a = 1'b1; @(negedge clk); rdy_a = 1'b0;
    chk("a_valid_clears", val_a, 0);

    for (int i = 0; i < 9; i++) begin
      cur_l = tbl[i].l; cur_r = tbl[i].r;
      if (tbl[i].rdy_pre || tbl[i].clr_pre) begin
        rdy_a = tbl[i].rdy_pre; clr_a = tbl[i].clr_pre;
        @(negedge clk);
        rdy_a = 1'b0; clr_a = 1'b0;
        if (tbl[i].rdy_pre) chk($sformatf("v%0d_pre_valid", i), val_a, 0);
        if (tbl[i].clr_pre) chk($sformatf("v%0d_pre_ovr", i), ovr_a, 0);
      end
      wait_post(tbl[i].rdy_post, tbl[i].clr_post);
      chk($sformatf("v%0d_valid", i), val_a, tbl[i].exp_v);
      chk($sformatf("v%0d_ovr", i),   ovr_a, tbl[i].exp_o);
      chk($sformatf("v%0d_left", i),  l_a,   tbl[i].exp_l);
      chk($sformatf("v%0d_right", i), r_a,   tbl[i].exp_r);
    end

    // Abort at bitcnt=40: outputs and flags retained, no post.
    cur_l = 24'h111111; cur_r = 24'h222222;
    wait_lvl_a(1'b0, 4096);
    wait_lvl_a(1'b1, 4096);
    edges_a(8, 1'b0, 4096);
    en_a = 1'b0;
    @(negedge clk);
    chk("abort_sclk", sclk_a, 0);
    chk("abort_lrck", lrck_a, 0);
    chk("abort_state", st_a, 0);
    repeat (1500) @(negedge clk);
    chk("abort_valid", val_a, 1);
    chk("abort_data", {l_a, r_a}, {24'hFEDCBA, 24'hC0FFEE});
    chk("abort_ovr", ovr_a, 0);

    // Asynchronous reset mid-frame, then restart timing.
    en_a = 1'b1;
    repeat (1000) @(negedge clk);
    #2 rst_a = 1'b1;
    #1 chk_reset_a("a_async_rst");
    @(negedge clk);
    rst_a = 1'b0;
    c = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e <= 8) chk($sformatf("mclk_e%0d", e), mclk_a, (e >> 1) & 1);
      if (sclk_a && c == 0) c = e;
    end
    chk("sclk_first_rise", c, 16);
    en_a = 1'b0;
  endtask

  // ---------------- instance B: random stream scoreboard ----------------
  logic [47:0] exp_q [$];
  int pb [$];
  int posts_b = 0;

  always @(negedge clk) begin
    if (val_b) begin
      posts_b++;
      pb.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_extra_post: got %0h expected none", {l_b, r_b});
      end else begin
        chk("b_sample", {l_b, r_b}, exp_q.pop_front());
      end
    end
  end

  task automatic run_b();
    int c = 0;
    for (int i = 0; i < 128; i++) begin
      bl[i] = 24'($urandom);
      br[i] = 24'($urandom_range(0, 32'h00FF_FFFF));
      if (i < 100) exp_q.push_back({bl[i], br[i]});
    end
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    en_b = 1'b1;
    while (posts_b < 100 && c < 60000) begin @(negedge clk); c++; end
    if (posts_b < 100) tmo("b_posts");
    en_b = 1'b0;
    if (pb.size() >= 2) chk("b_frame_period", pb[1] - pb[0], 512);
    chk("b_all_consumed", exp_q.size(), 0);
    chk("b_no_overrun", ovr_b, 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
